// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential chunk adder: FSM encoding and a
// sizing helper for the slice counter.
package seq_adder_pkg;

    // FSM state encoding shared by the adder and anything that observes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that indexes n slices; never narrower than 1 bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_rca.sv
// Combinational ripple-carry adder for one CHUNK-bit slice. Also reports the
// carry into the slice MSB so the caller can form signed overflow.
module chunk_rca #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    // Bit-serial ripple: c[i] is the carry into bit i.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            s[i]   = x[i] ^ y[i] ^ c[i];
            c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
        end
    end

    assign co       = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: adds one CHUNK-bit slice per enabled cycle,
// LSB slice first, and publishes sum/cout/ovf only when the last slice is done.
//
// Handshake: start is sampled on a rising edge with en=1 while the FSM is in
// IDLE or DONE; that edge is the accept edge. busy is high while RUN, done is
// high while DONE. Results on sum/cout/ovf change only on the completion edge.
// busy=0/done=0 means IDLE, busy=1 means RUN, done=1 means DONE.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = cnt_width(NCH);
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    // Refuse to elaborate when the operand does not split into whole slices.
    generate
        if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] psum;
    logic [CW-1:0]    cnt;
    logic             carry;

    logic [CHUNK-1:0] slice_s;
    logic             slice_co;
    logic             slice_c_msb;
    logic [WIDTH-1:0] s_ext;
    logic [WIDTH-1:0] psum_next;
    logic             accept;

    chunk_rca #(.CHUNK(CHUNK)) u_rca (
        .x        (a_sr[CHUNK-1:0]),
        .y        (b_sr[CHUNK-1:0]),
        .ci       (carry),
        .s        (slice_s),
        .co       (slice_co),
        .c_msb_in (slice_c_msb)
    );

    // New slice enters at the top of the partial sum so that after NCH
    // shifts the first (LSB) slice has reached bit 0.
    always_comb begin
        s_ext              = '0;
        s_ext[CHUNK-1:0]   = slice_s;
        psum_next          = (psum >> CHUNK) | (s_ext << (WIDTH - CHUNK));
    end

    assign accept = en && start && ((state == IDLE) || (state == DONE));

    // FSM, datapath shift registers and registered outputs; en=0 freezes all.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (en) begin
            if (accept) begin
                a_sr  <= a;
                b_sr  <= sub ? ~b : b;
                carry <= sub ? 1'b1 : cin;
                cnt   <= '0;
                state <= RUN;
                busy  <= 1'b1;
                done  <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        a_sr  <= a_sr >> CHUNK;
                        b_sr  <= b_sr >> CHUNK;
                        psum  <= psum_next;
                        carry <= slice_co;
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            sum   <= psum_next;
                            cout  <= slice_co;
                            ovf   <= slice_c_msb ^ slice_co;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder at WIDTH=16, CHUNK=4.
module tb_seq_chunk_adder;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         en;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks = 0;
    int errors = 0;

    // Expected results packed as {cout, ovf, sum}.
    logic [W+1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vcin;
        logic         vsub;
        logic [W-1:0] esum;
        logic         ecout;
        logic         eovf;
    } vec_t;

    vec_t vecs[8];

    seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .start (start),
        .sub   (sub),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: straight 17-bit arithmetic, overflow from operand/result signs.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mcin, input logic msub);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         c0;
        logic         v;
        bb   = msub ? ~mb : mb;
        c0   = msub ? 1'b1 : mcin;
        full = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, c0};
        v    = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
        return {full[W], v, full[W-1:0]};
    endfunction

    task automatic pop_and_compare(input string name);
        logic [W+1:0] e;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({name, "_sum"},  {16'd0, sum}, {16'd0, e[W-1:0]});
            check({name, "_cout"}, {31'd0, cout}, {31'd0, e[W+1]});
            check({name, "_ovf"},  {31'd0, ovf},  {31'd0, e[W]});
        end
    endtask

    // One full operation under continuous en: latency, no partial results,
    // result, and a one-cycle done pulse followed by IDLE.
    task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tcin, input logic tsub, input logic [W+1:0] exp);
        logic [W+1:0] prev;
        int           n;
        bit           seen;
        bit           stable;
        bit           busy_ok;
        @(negedge clk);
        a = ta; b = tb_; cin = tcin; sub = tsub; start = 1'b1;
        exp_q.push_back(exp);
        prev    = {cout, ovf, sum};
        n       = 0;
        seen    = 0;
        stable  = 1;
        busy_ok = 1;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (done) seen = 1;
            else begin
                if ({cout, ovf, sum} !== prev) stable = 0;
                if (busy !== 1'b1) busy_ok = 0;
            end
        end
        check({name, "_latency"}, n, 5);
        check({name, "_no_partial"}, {31'd0, stable}, 32'd1);
        check({name, "_busy_in_run"}, {31'd0, busy_ok}, 32'd1);
        pop_and_compare(name);
        @(posedge clk); #1;
        check({name, "_done_pulse"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[6] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
        vecs[7] = '{16'h0F0F, 16'h0F0F, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};

        rst = 1'b1; en = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;

        // Reset held two cycles
        repeat (2) @(posedge clk);
        #1;
        check("reset_sum",  {16'd0, sum}, 32'd0);
        check("reset_cout", {31'd0, cout}, 32'd0);
        check("reset_ovf",  {31'd0, ovf}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub,
                   {vecs[i].ecout, vecs[i].eovf, vecs[i].esum});
        end

        // Random operations against the model
        for (int i = 0; i < 20; i++) begin
            logic [W-1:0] ra, rb;
            logic         rc, rs;
            ra = W'($urandom_range(0, 16'hFFFF));
            rb = W'($urandom_range(0, 16'hFFFF));
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, model(ra, rb, rc, rs));
        end

        // Freeze mid-RUN for 3 cycles, plus an ignored start while busy
        begin
            bit early;
            early = 0;
            @(negedge clk);
            a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; start = 1'b1;
            exp_q.push_back(model(16'h1111, 16'h2222, 1'b0, 1'b0));
            for (int e = 1; e <= 8; e++) begin
                @(posedge clk); #1;
                start = 1'b0;
                if (e < 8 && done) early = 1;
                if (e == 2) en = 1'b0;
                if (e == 4) check("freeze_busy_held", {31'd0, busy}, 32'd1);
                if (e == 5) en = 1'b1;
                if (e == 6) begin start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; end
            end
            check("freeze_no_early_done", {31'd0, early}, 32'd0);
            check("freeze_done_edge8", {31'd0, done}, 32'd1);
            pop_and_compare("freeze");
            // DONE must also hold while frozen
            en = 1'b0;
            repeat (2) @(posedge clk);
            #1;
            check("freeze_done_held", {31'd0, done}, 32'd1);
            en = 1'b1;
            @(posedge clk); #1;
            check("freeze_done_release", {31'd0, done}, 32'd0);
        end

        // Reset abort on the second RUN cycle
        begin
            bit spurious;
            spurious = 0;
            @(negedge clk);
            a = 16'h4444; b = 16'h1111; cin = 1'b0; sub = 1'b0; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("abort_busy", {31'd0, busy}, 32'd0);
            check("abort_done", {31'd0, done}, 32'd0);
            check("abort_sum",  {16'd0, sum}, 32'd0);
            check("abort_flags", {30'd0, cout, ovf}, 32'd0);
            for (int e = 0; e < 8; e++) begin
                @(posedge clk); #1;
                if (done || busy) spurious = 1;
            end
            check("abort_no_done", {31'd0, spurious}, 32'd0);
        end

        // Back-to-back: start held high through DONE
        begin
            @(negedge clk);
            a = 16'h0001; b = 16'h0002; cin = 1'b0; sub = 1'b0; start = 1'b1;
            exp_q.push_back(model(16'h0001, 16'h0002, 1'b0, 1'b0));
            exp_q.push_back(model(16'hAAAA, 16'h5555, 1'b1, 1'b1));
            for (int e = 1; e <= 11; e++) begin
                @(posedge clk); #1;
                if (e == 4) check("b2b_no_early_done", {31'd0, done}, 32'd0);
                if (e == 5) begin
                    check("b2b_first_done", {31'd0, done}, 32'd1);
                    pop_and_compare("b2b_first");
                    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b1;
                end
                if (e == 6) begin
                    check("b2b_restart", {30'd0, busy, done}, 32'd2);
                    start = 1'b0;
                end
                if (e == 10) begin
                    check("b2b_second_done", {31'd0, done}, 32'd1);
                    pop_and_compare("b2b_second");
                end
                if (e == 11) check("b2b_done_one_cycle", {31'd0, done}, 32'd0);
            end
        end

        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
